// File: rtl/rfft_npt.sv
// rfft_npt: in-place radix-2 DIT real-input FFT, one butterfly per cycle, output scaled by 1/N.
module rfft_npt #(
  parameter int DATA_BIT   = 16,
  parameter int ADDR_BIT   = 3,
  parameter int MEM_HEIGHT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_BIT-1:0] in_data,
  input  logic                       bypass_en,
  output logic [ADDR_BIT-2:0]        tw_addr,
  input  logic signed [DATA_BIT-1:0] tw_r,
  input  logic signed [DATA_BIT-1:0] tw_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_BIT-1:0] out_re,
  output logic signed [DATA_BIT-1:0] out_im,
  output logic [ADDR_BIT-1:0]        out_idx,
  output logic                       busy
);
  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [ADDR_BIT-1:0] A_ONE = ADDR_BIT'(1);
  localparam logic [ADDR_BIT-1:0] A_LAST = ADDR_BIT'(MEM_HEIGHT - 1);
  localparam logic [ADDR_BIT-1:0] S_LAST = ADDR_BIT'(ADDR_BIT - 1);

  logic [1:0] state_q, state_d;
  logic [ADDR_BIT-1:0] load_q, load_d, drain_q, drain_d, stage_q, stage_d;
  logic [ADDR_BIT-2:0] bf_q, bf_d;
  logic byp_q, byp_d;
  logic signed [DATA_BIT-1:0] mem_re_q [MEM_HEIGHT];
  logic signed [DATA_BIT-1:0] mem_im_q [MEM_HEIGHT];

  logic [ADDR_BIT-2:0] mask, pos;
  logic [ADDR_BIT-1:0] half, a_addr, b_addr, rd_addr;
  logic signed [DATA_BIT-1:0] a_re, a_im, b_re, b_im, na_re, na_im, nb_re, nb_im;
  logic signed [2*DATA_BIT-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [DATA_BIT:0] t_re, t_im;
  logic load_we;

  function automatic logic [ADDR_BIT-1:0] bitrev(input logic [ADDR_BIT-1:0] x);
    for (int i = 0; i < ADDR_BIT; i++) bitrev[i] = x[ADDR_BIT-1-i];
  endfunction

  // Butterfly j of stage s: pos = low s bits of j, a = group*2*half + pos.
  always_comb begin
    mask   = ~({(ADDR_BIT-1){1'b1}} << stage_q);
    pos    = bf_q & mask;
    half   = A_ONE << stage_q;
    a_addr = {bf_q & ~mask, 1'b0} | {1'b0, pos};
    b_addr = a_addr | half;
    a_re   = mem_re_q[a_addr];
    a_im   = mem_im_q[a_addr];
    b_re   = mem_re_q[b_addr];
    b_im   = mem_im_q[b_addr];
    p_rr   = b_re * tw_r;
    p_ii   = b_im * tw_i;
    p_ri   = b_re * tw_i;
    p_ir   = b_im * tw_r;
    t_re   = (DATA_BIT+1)'((p_rr - p_ii) >>> (DATA_BIT-2));
    t_im   = (DATA_BIT+1)'((p_ri + p_ir) >>> (DATA_BIT-2));
    na_re  = DATA_BIT'(($signed({a_re[DATA_BIT-1], a_re}) + t_re) >>> 1);
    na_im  = DATA_BIT'(($signed({a_im[DATA_BIT-1], a_im}) + t_im) >>> 1);
    nb_re  = DATA_BIT'(($signed({a_re[DATA_BIT-1], a_re}) - t_re) >>> 1);
    nb_im  = DATA_BIT'(($signed({a_im[DATA_BIT-1], a_im}) - t_im) >>> 1);
  end

  always_comb begin
    load_we   = (state_q == LOAD) && in_valid;
    in_ready  = state_q == LOAD;
    busy      = state_q != LOAD;
    out_valid = state_q == DRAIN;
    tw_addr   = (state_q == CALC) ? pos << (ADDR_BIT-1-stage_q) : '0;
    rd_addr   = byp_q ? bitrev(drain_q) : drain_q;
    out_re    = out_valid ? mem_re_q[rd_addr] : '0;
    out_im    = out_valid ? mem_im_q[rd_addr] : '0;
    out_idx   = out_valid ? drain_q : '0;
  end

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    bf_d    = bf_q;
    stage_d = stage_q;
    drain_d = drain_q;
    byp_d   = byp_q;
    if (load_we) begin
      load_d = (load_q == A_LAST) ? '0 : load_q + A_ONE;
      if (load_q == A_LAST) begin
        byp_d   = bypass_en;
        state_d = bypass_en ? DRAIN : CALC;
      end
    end
    if (state_q == CALC) begin
      bf_d = bf_q + 1'b1;
      if (&bf_q) begin
        stage_d = (stage_q == S_LAST) ? '0 : stage_q + A_ONE;
        state_d = (stage_q == S_LAST) ? DRAIN : CALC;
      end
    end
    if (state_q == DRAIN && out_ready) begin
      drain_d = (drain_q == A_LAST) ? '0 : drain_q + A_ONE;
      if (drain_q == A_LAST) begin
        state_d = LOAD;
        byp_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      load_q  <= '0;
      bf_q    <= '0;
      stage_q <= '0;
      drain_q <= '0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      bf_q    <= bf_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
      byp_q   <= byp_d;
    end
  end

  // Working memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_re_q[bitrev(load_q)] <= in_data;
      mem_im_q[bitrev(load_q)] <= '0;
    end else if (state_q == CALC) begin
      mem_re_q[a_addr] <= na_re;
      mem_im_q[a_addr] <= na_im;
      mem_re_q[b_addr] <= nb_re;
      mem_im_q[b_addr] <= nb_im;
    end
  end
endmodule

// File: tb/tb_rfft_npt.sv
// tb_rfft_npt: directed frames with hand-computed bins for the 8-point rfft_npt.
module tb_rfft_npt;
  localparam int DB = 16;
  localparam int AB = 3;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic bypass_en = 1'b0;
  logic out_ready = 1'b1;
  logic signed [DB-1:0] in_data = '0;
  logic signed [DB-1:0] tw_r, tw_i, out_re, out_im;
  logic in_ready, out_valid, busy;
  logic [AB-2:0] tw_addr;
  logic [AB-1:0] out_idx;
  int checks = 0;
  int errors = 0;
  int smp[N], er[N], ei[N];

  always #5 clk = ~clk;

  rfft_npt #(.DATA_BIT(DB), .ADDR_BIT(AB), .MEM_HEIGHT(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bypass_en(bypass_en), .tw_addr(tw_addr), .tw_r(tw_r), .tw_i(tw_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .busy(busy)
  );

  always_comb begin
    tw_r = (tw_addr == 2'd0) ? 16'sd16384 : (tw_addr == 2'd1) ? 16'sd11585 :
           (tw_addr == 2'd2) ? 16'sd0 : -16'sd11585;
    tw_i = (tw_addr == 2'd0) ? 16'sd0 : (tw_addr == 2'd1) ? -16'sd11585 :
           (tw_addr == 2'd2) ? -16'sd16384 : -16'sd11585;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit byp);
    for (int i = 0; i < N; i++) begin
      in_valid  = 1'b1;
      in_data   = 16'(smp[i]);
      bypass_en = byp && (i == N - 1);
      chk("in_ready_load", int'(in_ready), 1);
      tick();
    end
    in_valid  = 1'b0;
    bypass_en = 1'b0;
  endtask

  task automatic wait_drain(input int exp_cyc);
    int n = 0;
    chk("busy_after_load", int'(busy), 1);
    while (!out_valid && n < 200) begin
      n++;
      tick();
    end
    chk("cycles_to_drain", n, exp_cyc);
  endtask

  task automatic drain(input string tag, input int stall);
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      chk({tag, "_valid"}, int'(out_valid), 1);
      chk({tag, "_idx"}, int'(out_idx), k);
      chk({tag, "_re"}, int'(out_re), er[k]);
      chk({tag, "_im"}, int'(out_im), ei[k]);
      if (k == 0) chk({tag, "_tw_drain"}, int'(tw_addr), 0);
      if (k == stall) begin
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          tick();
          chk({tag, "_hold_valid"}, int'(out_valid), 1);
          chk({tag, "_hold_idx"}, int'(out_idx), k);
          chk({tag, "_hold_re"}, int'(out_re), er[k]);
          chk({tag, "_hold_im"}, int'(out_im), ei[k]);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    chk({tag, "_end_in_ready"}, int'(in_ready), 1);
    chk({tag, "_end_busy"}, int'(busy), 0);
    chk({tag, "_end_valid"}, int'(out_valid), 0);
    chk({tag, "_end_re"}, int'(out_re), 0);
    chk({tag, "_end_idx"}, int'(out_idx), 0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_re", int'(out_re), 0);
    chk("rst_im", int'(out_im), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_tw", int'(tw_addr), 0);
    rst = 1'b0;

    smp = '{1000, 0, 0, 0, 0, 0, 0, 0};
    er  = '{125, 125, 125, 125, 125, 125, 125, 125};
    ei  = '{0, 0, 0, 0, 0, 0, 0, 0};
    send(1'b0);
    wait_drain(12);
    drain("imp", -1);

    smp = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    er  = '{1000, 0, 0, 0, 0, 0, 0, 0};
    send(1'b0);
    wait_drain(12);
    drain("dc", -1);

    smp = '{1000, -1000, 1000, -1000, 1000, -1000, 1000, -1000};
    er  = '{0, 0, 0, 0, 1000, 0, 0, 0};
    send(1'b0);
    wait_drain(12);
    drain("alt", -1);

    smp = '{0, 1000, 0, 0, 0, 0, 0, 0};
    er  = '{125, 88, 0, -89, -125, -88, 0, 88};
    ei  = '{0, -89, -125, -89, 0, 88, 125, 88};
    send(1'b0);
    wait_drain(12);
    drain("shift", -1);

    smp = '{0, 1, 2, 3, 4, 5, 6, 7};
    er  = '{0, 1, 2, 3, 4, 5, 6, 7};
    ei  = '{0, 0, 0, 0, 0, 0, 0, 0};
    send(1'b1);
    wait_drain(0);
    drain("byp", -1);

    send(1'b1);
    wait_drain(0);
    drain("bp", 2);

    smp = '{1000, 0, 0, 0, 0, 0, 0, 0};
    send(1'b0);
    repeat (4) tick();
    chk("mid_calc_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_tw", int'(tw_addr), 0);
    er = '{125, 125, 125, 125, 125, 125, 125, 125};
    send(1'b0);
    wait_drain(12);
    drain("postrst", -1);

    send(1'b0);
    in_valid = 1'b1;
    in_data  = 16'sd7777;
    chk("busyin_in_ready", int'(in_ready), 0);
    wait_drain(12);
    chk("busyin_drain_in_ready", int'(in_ready), 0);
    drain("busyin", -1);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
